// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, owner
// encoding and the default abort limit for a stalled memory access.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // Maximum ACCESS cycles without mem_ready before the access is aborted
  localparam int TIMEOUT_DEFAULT = 15;

  // Wait counter width; covers the full legal TIMEOUT range 2..255
  localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin selector. A lone requester always wins; when both
// request, the one that did not own the port last time is granted.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_cpu,
  input  logic req_dma,
  input  logic last,
  output logic gnt_valid,
  output logic gnt
);

  // Pick the winner; gnt is only meaningful while gnt_valid is high
  always_comb begin
    gnt_valid = req_cpu | req_dma;
    gnt       = OWN_CPU;
    if (req_cpu && req_dma) begin
      gnt = (last == OWN_DMA) ? OWN_CPU : OWN_DMA;
    end else if (req_dma) begin
      gnt = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between the multicycle CPU
// controller and the loader/DMA engine. One access is in flight at a time:
// IDLE grants a requester and latches its command, ACCESS holds the memory
// strobe until mem_ready or the wait limit, RESP pulses ack (and err on an
// abort) to the owner for one cycle. All outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // Counter value on the last ACCESS cycle allowed before an abort
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  owner_t            owner;
  owner_t            last_owner;
  logic              lat_we;
  logic [WAIT_W-1:0] wait_cnt;
  logic              gnt_valid;
  logic              gnt;

  arb_rr2 u_arb (
    .req_cpu   (cpu_req),
    .req_dma   (dma_req),
    .last      (last_owner),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // Transaction FSM: grant and latch, drive memory, report to the owner
  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      lat_we     <= 1'b0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      dma_rdata  <= '0;
      dma_ack    <= 1'b0;
      dma_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner      <= owner_t'(gnt);
            last_owner <= owner_t'(gnt);
            wait_cnt   <= '0;
            mem_en     <= 1'b1;
            if (gnt == OWN_DMA) begin
              lat_we    <= dma_we;
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
            end else begin
              lat_we    <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
            state <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (mem_ready) begin
            if (!lat_we) begin
              if (owner == OWN_DMA) dma_rdata <= mem_rdata;
              else                  cpu_rdata <= mem_rdata;
            end
            if (owner == OWN_DMA) dma_ack <= 1'b1;
            else                  cpu_ack <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ST_RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            if (owner == OWN_DMA) begin
              dma_rdata <= '0;
              dma_ack   <= 1'b1;
              dma_err   <= 1'b1;
            end else begin
              cpu_rdata <= '0;
              cpu_ack   <= 1'b1;
              cpu_err   <= 1'b1;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          cpu_ack <= 1'b0;
          cpu_err <= 1'b0;
          dma_ack <= 1'b0;
          dma_err <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              CLK = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic              cpu_ack, cpu_err, dma_ack, dma_err;
  logic              mem_en, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: last owner (1 = DMA) and each requester's read data
  bit          m_last_dma;
  logic [31:0] m_cpu_rdata, m_dma_rdata;

  // Observations of the most recent transaction
  int          obs_lat, obs_en_cycles;
  bit          obs_bus_stable, obs_gap_busy;
  logic        obs_cpu_ack, obs_dma_ack, obs_cpu_err, obs_dma_err, obs_we;
  logic [31:0] obs_cpu_rdata, obs_dma_rdata, obs_addr, obs_wdata;
  logic [31:0] obs_cpu_rdata_gap, obs_dma_rdata_gap;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    tick;
    tick;
    rst = 1'b0;
    m_last_dma  = 1'b1;
    m_cpu_rdata = '0;
    m_dma_rdata = '0;
  endtask

  // Drive one transaction; the memory answers after 'waits' wait cycles
  // with data 'rdval'. Records latency (edge of ack sampling relative to the
  // request-sampling edge N), bus contents and the state after the gap cycle.
  task automatic run_txn(input bit creq, input bit dreq, input bit cwe, input bit dwe,
                         input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic [31:0] daddr, input logic [31:0] dwd,
                         input logic [31:0] rdval, input int waits);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    mem_ready = 1'b0;
    tick;
    obs_lat = -1; obs_en_cycles = 0; obs_bus_stable = 1;
    obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
    cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom);
    dma_addr = $urandom; dma_wdata = $urandom; dma_we = 1'($urandom);
    for (int k = 0; k < 40; k++) begin
      if (cpu_ack || dma_ack || cpu_err || dma_err) begin
        obs_lat = k + 1;
        break;
      end
      if (mem_en) begin
        obs_en_cycles++;
        if (mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_we !== obs_we)
          obs_bus_stable = 0;
        mem_ready = ((obs_en_cycles - 1) == waits);
        mem_rdata = mem_ready ? rdval : $urandom;
      end else begin
        mem_ready = 1'b0;
      end
      tick;
    end
    obs_cpu_ack = cpu_ack; obs_dma_ack = dma_ack;
    obs_cpu_err = cpu_err; obs_dma_err = dma_err;
    obs_cpu_rdata = cpu_rdata; obs_dma_rdata = dma_rdata;
    cpu_req = 0; dma_req = 0;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    tick;
    obs_gap_busy = cpu_ack | dma_ack | cpu_err | dma_err | mem_en;
    obs_cpu_rdata_gap = cpu_rdata; obs_dma_rdata_gap = dma_rdata;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if ({cpu_ack, cpu_err, dma_ack, dma_err, mem_en, mem_we} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b expected 000000", {cpu_ack, cpu_err, dma_ack, dma_err, mem_en, mem_we});
    else n_pass++;
    n_checks++;
    if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0)
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, dma_rdata);
    else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("[TB] FAIL reset_membus: got %h/%h expected 0/0", mem_addr, mem_wdata);
    else n_pass++;
  endtask

  task automatic test_cpu_read;
    run_txn(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    n_checks++;
    if (obs_lat !== 2) $display("[TB] FAIL cpu_read_latency: got %0d expected 2", obs_lat);
    else n_pass++;
    n_checks++;
    if ({obs_cpu_ack, obs_cpu_err, obs_dma_ack, obs_dma_err} !== 4'b1000)
      $display("[TB] FAIL cpu_read_acks: got %b expected 1000", {obs_cpu_ack, obs_cpu_err, obs_dma_ack, obs_dma_err});
    else n_pass++;
    n_checks++;
    if (obs_cpu_rdata !== 32'hDEADBEEF) $display("[TB] FAIL cpu_read_data: got %h expected deadbeef", obs_cpu_rdata);
    else n_pass++;
    n_checks++;
    if (obs_addr !== 32'h100 || obs_we !== 1'b0) $display("[TB] FAIL cpu_read_bus: got %h/%b expected 100/0", obs_addr, obs_we);
    else n_pass++;
    n_checks++;
    if (obs_gap_busy !== 1'b0) $display("[TB] FAIL cpu_read_ack_pulse: got %b expected 0", obs_gap_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_addr [3] = '{32'h100, 32'h200, 32'h100};
    logic [1:0]  exp_ack  [3] = '{2'b10, 2'b01, 2'b10};
    do_reset;
    for (int i = 0; i < 3; i++) begin
      run_txn(1, 1, 0, 0, 32'h100, 32'h0, 32'h200, 32'h0, 32'hA0000001 + i, 0);
      n_checks++;
      if (obs_addr !== exp_addr[i]) $display("[TB] FAIL b2b_addr%0d: got %h expected %h", i, obs_addr, exp_addr[i]);
      else n_pass++;
      n_checks++;
      if ({obs_cpu_ack, obs_dma_ack} !== exp_ack[i]) $display("[TB] FAIL b2b_owner%0d: got %b expected %b", i, {obs_cpu_ack, obs_dma_ack}, exp_ack[i]);
      else n_pass++;
    end
  endtask

  task automatic test_dma_write_wait;
    run_txn(0, 1, 0, 1, 32'h0, 32'h0, 32'h40, 32'h12345678, 32'hBAD0BAD0, 3);
    n_checks++;
    if (obs_en_cycles !== 4) $display("[TB] FAIL dma_write_en_cycles: got %0d expected 4", obs_en_cycles);
    else n_pass++;
    n_checks++;
    if (obs_lat !== 5) $display("[TB] FAIL dma_write_latency: got %0d expected 5", obs_lat);
    else n_pass++;
    n_checks++;
    if ({obs_dma_ack, obs_dma_err, obs_cpu_ack} !== 3'b100)
      $display("[TB] FAIL dma_write_acks: got %b expected 100", {obs_dma_ack, obs_dma_err, obs_cpu_ack});
    else n_pass++;
    n_checks++;
    if (obs_addr !== 32'h40 || obs_wdata !== 32'h12345678 || obs_we !== 1'b1 || !obs_bus_stable)
      $display("[TB] FAIL dma_write_bus: got %h/%h/%b stable=%0d expected 40/12345678/1 stable=1", obs_addr, obs_wdata, obs_we, obs_bus_stable);
    else n_pass++;
    n_checks++;
    if (obs_dma_rdata !== 32'hA0000002) $display("[TB] FAIL dma_write_keeps_rdata: got %h expected a0000002", obs_dma_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout;
    run_txn(1, 0, 0, 0, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 1000);
    n_checks++;
    if (obs_en_cycles !== TIMEOUT || obs_lat !== TIMEOUT + 1)
      $display("[TB] FAIL timeout_length: got en=%0d lat=%0d expected en=%0d lat=%0d", obs_en_cycles, obs_lat, TIMEOUT, TIMEOUT + 1);
    else n_pass++;
    n_checks++;
    if ({obs_cpu_ack, obs_cpu_err, obs_dma_ack, obs_dma_err} !== 4'b1100)
      $display("[TB] FAIL timeout_flags: got %b expected 1100", {obs_cpu_ack, obs_cpu_err, obs_dma_ack, obs_dma_err});
    else n_pass++;
    n_checks++;
    if (obs_cpu_rdata !== 32'h0) $display("[TB] FAIL timeout_rdata: got %h expected 0", obs_cpu_rdata);
    else n_pass++;
    run_txn(1, 0, 0, 0, 32'h304, 32'h0, 32'h0, 32'h0, 32'h5555AAAA, TIMEOUT - 1);
    n_checks++;
    if (obs_en_cycles !== TIMEOUT || obs_lat !== TIMEOUT + 1)
      $display("[TB] FAIL last_cycle_length: got en=%0d lat=%0d expected en=%0d lat=%0d", obs_en_cycles, obs_lat, TIMEOUT, TIMEOUT + 1);
    else n_pass++;
    n_checks++;
    if ({obs_cpu_ack, obs_cpu_err} !== 2'b10 || obs_cpu_rdata !== 32'h5555AAAA)
      $display("[TB] FAIL last_cycle_completes: got ack/err=%b data=%h expected 10 data=5555aaaa", {obs_cpu_ack, obs_cpu_err}, obs_cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access;
    bit early_ack = 0;
    do_reset;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h500;
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      early_ack |= cpu_ack | dma_ack | cpu_err | dma_err;
    end
    rst = 1'b1;
    dma_req = 1;
    tick;
    rst = 1'b0;
    m_last_dma = 1'b1;
    n_checks++;
    if ({early_ack, cpu_ack, cpu_err, dma_ack, dma_err, mem_en} !== 6'b0)
      $display("[TB] FAIL midrst_no_ack: got %b expected 000000", {early_ack, cpu_ack, cpu_err, dma_ack, dma_err, mem_en});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0 || cpu_rdata !== 32'h0)
      $display("[TB] FAIL midrst_cleared: got addr=%h rdata=%h expected 0/0", mem_addr, cpu_rdata);
    else n_pass++;
    run_txn(1, 1, 0, 0, 32'h500, 32'h0, 32'h600, 32'h0, 32'hC0FFEE00, 1);
    n_checks++;
    if (obs_lat !== 3 || {obs_cpu_ack, obs_dma_ack} !== 2'b10 || obs_cpu_rdata !== 32'hC0FFEE00)
      $display("[TB] FAIL midrst_resume: got lat=%0d acks=%b data=%h expected lat=3 acks=10 data=c0ffee00", obs_lat, {obs_cpu_ack, obs_dma_ack}, obs_cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_random;
    do_reset;
    for (int t = 0; t < 40; t++) begin
      bit creq, dreq, cwe, dwe, own_dma, exp_err, own_we;
      int waits, exp_lat;
      logic [31:0] caddr, daddr, cwd, dwd, rdval, exp_addr;
      creq = 1'($urandom); dreq = 1'($urandom);
      if (!creq && !dreq) creq = 1;
      cwe = 1'($urandom); dwe = 1'($urandom);
      caddr = $urandom; daddr = $urandom; cwd = $urandom; dwd = $urandom; rdval = $urandom;
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2) : $urandom_range(0, 3);
      // Round robin: a lone requester wins, a tie goes to the other party
      own_dma  = (creq && dreq) ? !m_last_dma : dreq;
      own_we   = own_dma ? dwe : cwe;
      exp_addr = own_dma ? daddr : caddr;
      exp_err  = (waits >= TIMEOUT);
      exp_lat  = 1 + (exp_err ? TIMEOUT : waits + 1);
      run_txn(creq, dreq, cwe, dwe, caddr, cwd, daddr, dwd, rdval, waits);
      m_last_dma = own_dma;
      if (exp_err) begin
        if (own_dma) m_dma_rdata = '0; else m_cpu_rdata = '0;
      end else if (!own_we) begin
        if (own_dma) m_dma_rdata = rdval; else m_cpu_rdata = rdval;
      end
      n_checks++;
      if (obs_lat !== exp_lat || obs_addr !== exp_addr || obs_we !== own_we || !obs_bus_stable)
        $display("[TB] FAIL rand%0d_access: got lat=%0d addr=%h we=%b stable=%0d expected lat=%0d addr=%h we=%b stable=1",
                 t, obs_lat, obs_addr, obs_we, obs_bus_stable, exp_lat, exp_addr, own_we);
      else n_pass++;
      n_checks++;
      if ({obs_cpu_ack, obs_cpu_err, obs_dma_ack, obs_dma_err} !== {!own_dma, !own_dma && exp_err, own_dma, own_dma && exp_err})
        $display("[TB] FAIL rand%0d_flags: got %b expected %b", t, {obs_cpu_ack, obs_cpu_err, obs_dma_ack, obs_dma_err},
                 {!own_dma, !own_dma && exp_err, own_dma, own_dma && exp_err});
      else n_pass++;
      n_checks++;
      if (obs_cpu_rdata !== m_cpu_rdata || obs_dma_rdata !== m_dma_rdata || obs_cpu_rdata_gap !== m_cpu_rdata ||
          obs_dma_rdata_gap !== m_dma_rdata || obs_gap_busy !== 1'b0)
        $display("[TB] FAIL rand%0d_rdata: got %h/%h gap %h/%h busy=%b expected %h/%h busy=0", t, obs_cpu_rdata, obs_dma_rdata,
                 obs_cpu_rdata_gap, obs_dma_rdata_gap, obs_gap_busy, m_cpu_rdata, m_dma_rdata);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_back_to_back;
    test_dma_write_wait;
    test_timeout;
    test_reset_mid_access;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- TIMEOUT, 15, maximum ACCESS-state cycles without mem_ready before abort; legal range 2..255.
REQ-002 Ports SHALL be as follows, one per line:
- CLK  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU (multicycle controller) access request.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_ack  out  1  CPU completion pulse.
- cpu_err  out  1  CPU timeout flag.
- dma_req  in  1  loader/DMA access request.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data.
- dma_ack  out  1  DMA completion pulse.
- dma_err  out  1  DMA timeout flag.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion, variable latency.

Function
REQ-003 FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 IDLE: if no request, remain in IDLE.
REQ-005 IDLE with any request: select owner, latch owner's we/addr/wdata into internal registers, go to ACCESS.
REQ-006 Arbitration SHALL be round-robin on a 1-bit last-owner pointer: single requester wins; both requesting, the non-last owner wins; pointer updated on grant.
REQ-007 ACCESS: mem_en=1; mem_we, mem_addr, mem_wdata SHALL be driven only from latched registers.
REQ-008 ACCESS with mem_ready=1: capture mem_rdata into owner's rdata register (reads only; writes leave rdata unchanged), go to RESP.
REQ-009 Wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ready.
REQ-010 ACCESS with counter==TIMEOUT-1 and mem_ready=0: abort, owner's rdata:=0, go to RESP with err pending.
REQ-011 mem_ready=1 in the same cycle as timeout SHALL win; completion is normal, no error.
REQ-012 RESP: owner's ack=1 for exactly one cycle; owner's err=1 in that cycle iff aborted; then go to IDLE.
REQ-013 Non-owner ack/err SHALL be 0 at all times; mem_en=0 in IDLE and RESP.
REQ-014 Latency with zero-wait memory: request sampled in IDLE at cycle N, ack at cycle N+2; each wait cycle adds one.
REQ-015 Requester SHALL hold req/we/addr/wdata stable until its ack and drop or renew req in the following cycle; changes on inputs during ACCESS SHALL NOT affect the access in flight.
REQ-016 rdata registers SHALL hold their value until the owner's next completed read or abort.
REQ-017 mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-018 rst SHALL force state IDLE, pointer to DMA (so CPU wins first tie), counter 0, all outputs 0, including rdata, mem_addr and mem_wdata.
REQ-019 rst asserted in ACCESS or RESP SHALL abandon the transaction with no ack/err pulse; rst has priority over all transitions.

Structure
REQ-020 State encoding, owner encoding and the TIMEOUT default SHALL live in the shared CPU package.
REQ-021 Round-robin selection SHALL be one sub-module, arb_rr2 (two requests, pointer in, grant out); the FSM, latches and counter stay in mem_port_arbiter.

Verification
REQ-022 CPU read, zero-wait memory, mem_rdata=0xDEADBEEF: cpu_ack at N+2, cpu_rdata=0xDEADBEEF, dma_ack=0.
REQ-023 Both requesting after reset: CPU served first, DMA second, then CPU again; mem_addr alternates 0x100/0x200.
REQ-024 DMA write, addr 0x40, data 0x12345678, 3 wait cycles: mem_en high 4 cycles, dma_ack at N+5, dma_err=0.
REQ-025 mem_ready never asserted with TIMEOUT=15: abort after 15 ACCESS cycles, cpu_ack=cpu_err=1 one cycle, cpu_rdata=0; mem_ready coincident with the last cycle completes normally.
REQ-026 rst mid-ACCESS: next cycle IDLE, all outputs 0, no ack; pending CPU request then served normally.
